// File: rtl/regfile_csr.sv
`default_nettype none
// ============================================================================
// Module   : regfile_csr
// Purpose  : Architectural state for the writeback stage: 32x32 integer
//            register file, machine-mode CSRs, 64-bit cycle/instret
//            counters and trap capture (mepc/mcause/mstatus).
// Revision : 1.0 - initial release
// ============================================================================
module regfile_csr #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter bit          BYPASS      = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  rs1_addr,
    output logic [31:0] rs1_data,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs2_data,
    input  logic        reg_w_enabled,
    input  logic [4:0]  reg_w_addr,
    input  logic [31:0] reg_w_data,
    input  logic [11:0] csr_r_addr,
    output logic [31:0] csr_r_data,
    output logic        csr_r_illegal,
    input  logic        csr_w_enabled,
    input  logic [11:0] csr_w_addr,
    input  logic [31:0] csr_w_data,
    input  logic        retire,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out
);

    localparam logic [11:0] c_mstatus   = 12'h300;
    localparam logic [11:0] c_mie       = 12'h304;
    localparam logic [11:0] c_mtvec     = 12'h305;
    localparam logic [11:0] c_mscratch  = 12'h340;
    localparam logic [11:0] c_mepc      = 12'h341;
    localparam logic [11:0] c_mcause    = 12'h342;
    localparam logic [11:0] c_mcycle    = 12'hB00;
    localparam logic [11:0] c_mcycleh   = 12'hB80;
    localparam logic [11:0] c_minstret  = 12'hB02;
    localparam logic [11:0] c_minstreth = 12'hB82;
    localparam logic [11:0] c_cycle     = 12'hC00;
    localparam logic [11:0] c_cycleh    = 12'hC80;
    localparam logic [11:0] c_instret   = 12'hC02;
    localparam logic [11:0] c_instreth  = 12'hC82;

    // Only MIE (bit 3) and MPIE (bit 7) exist in mstatus
    localparam logic [31:0] c_mstatus_mask = 32'h0000_0088;
    localparam logic [31:0] c_align_mask   = 32'hFFFF_FFFC;

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic [31:0] mstatus_q, mstatus_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    logic        w_bypass_en;
    logic [31:0] w_csr_wmasked;
    logic [31:0] w_csr_rstate;
    logic        w_csr_rwritable;
    logic        w_unused;

    // The low PC bits are dropped when capturing mepc
    assign w_unused = &{1'b0, trap_pc[1:0]};

    generate
        if (BYPASS) begin : g_bypass
            assign w_bypass_en = 1'b1;
        end else begin : g_no_bypass
            assign w_bypass_en = 1'b0;
        end
    endgenerate

    // Integer read ports: x0 hardwired to zero, optional write forwarding
    always_comb begin
        rs1_data = 32'h0;
        rs2_data = 32'h0;
        if (rs1_addr != 5'd0) begin
            if (w_bypass_en && reg_w_enabled && (reg_w_addr == rs1_addr))
                rs1_data = reg_w_data;
            else
                rs1_data = regs_q[rs1_addr];
        end
        if (rs2_addr != 5'd0) begin
            if (w_bypass_en && reg_w_enabled && (reg_w_addr == rs2_addr))
                rs2_data = reg_w_data;
            else
                rs2_data = regs_q[rs2_addr];
        end
    end

    // Integer file next state: reset clears, x0 never written
    always_comb begin
        regs_d = regs_q;
        if (reg_w_enabled && (reg_w_addr != 5'd0))
            regs_d[reg_w_addr] = reg_w_data;
        if (!rstn) begin
            for (int i = 0; i < 32; i++)
                regs_d[i] = 32'h0;
        end
        regs_d[0] = 32'h0;
    end

    // CSR write value after applying per-register masks
    always_comb begin
        w_csr_wmasked = csr_w_data;
        case (csr_w_addr)
            c_mstatus:       w_csr_wmasked = csr_w_data & c_mstatus_mask;
            c_mtvec, c_mepc: w_csr_wmasked = csr_w_data & c_align_mask;
            default:         w_csr_wmasked = csr_w_data;
        endcase
    end

    // CSR read decode from current state
    always_comb begin
        w_csr_rstate    = 32'h0;
        w_csr_rwritable = 1'b1;
        csr_r_illegal   = 1'b0;
        case (csr_r_addr)
            c_mstatus:   w_csr_rstate = mstatus_q;
            c_mie:       w_csr_rstate = mie_q;
            c_mtvec:     w_csr_rstate = mtvec_q;
            c_mscratch:  w_csr_rstate = mscratch_q;
            c_mepc:      w_csr_rstate = mepc_q;
            c_mcause:    w_csr_rstate = mcause_q;
            c_mcycle:    w_csr_rstate = mcycle_q[31:0];
            c_mcycleh:   w_csr_rstate = mcycle_q[63:32];
            c_minstret:  w_csr_rstate = minstret_q[31:0];
            c_minstreth: w_csr_rstate = minstret_q[63:32];
            c_cycle: begin
                w_csr_rstate    = mcycle_q[31:0];
                w_csr_rwritable = 1'b0;
            end
            c_cycleh: begin
                w_csr_rstate    = mcycle_q[63:32];
                w_csr_rwritable = 1'b0;
            end
            c_instret: begin
                w_csr_rstate    = minstret_q[31:0];
                w_csr_rwritable = 1'b0;
            end
            c_instreth: begin
                w_csr_rstate    = minstret_q[63:32];
                w_csr_rwritable = 1'b0;
            end
            default: begin
                w_csr_rwritable = 1'b0;
                csr_r_illegal   = 1'b1;
            end
        endcase
    end

    // CSR read data with same-cycle forwarding of writable registers
    always_comb begin
        if (w_bypass_en && csr_w_enabled && w_csr_rwritable && (csr_w_addr == csr_r_addr))
            csr_r_data = w_csr_wmasked;
        else
            csr_r_data = w_csr_rstate;
    end

    // CSR next state: increment, then CSR write, then trap, then reset
    always_comb begin
        mstatus_d  = mstatus_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, retire};
        if (csr_w_enabled) begin
            case (csr_w_addr)
                c_mstatus:   mstatus_d  = w_csr_wmasked;
                c_mie:       mie_d      = w_csr_wmasked;
                c_mtvec:     mtvec_d    = w_csr_wmasked;
                c_mscratch:  mscratch_d = w_csr_wmasked;
                c_mepc:      mepc_d     = w_csr_wmasked;
                c_mcause:    mcause_d   = w_csr_wmasked;
                c_mcycle:    mcycle_d   = {mcycle_q[63:32], w_csr_wmasked};
                c_mcycleh:   mcycle_d   = {w_csr_wmasked, mcycle_q[31:0]};
                c_minstret:  minstret_d = {minstret_q[63:32], w_csr_wmasked};
                c_minstreth: minstret_d = {w_csr_wmasked, minstret_q[31:0]};
                default:     ;
            endcase
        end
        if (trap_valid) begin
            mepc_d       = {trap_pc[31:2], 2'b00};
            mcause_d     = trap_cause;
            mstatus_d    = 32'h0;
            mstatus_d[7] = mstatus_q[3];
        end
        if (!rstn) begin
            mstatus_d  = 32'h0;
            mie_d      = 32'h0;
            mtvec_d    = MTVEC_RESET;
            mscratch_d = 32'h0;
            mepc_d     = 32'h0;
            mcause_d   = 32'h0;
            mcycle_d   = 64'h0;
            minstret_d = 64'h0;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        regs_q     <= regs_d;
        mstatus_q  <= mstatus_d;
        mie_q      <= mie_d;
        mtvec_q    <= mtvec_d;
        mscratch_q <= mscratch_d;
        mepc_q     <= mepc_d;
        mcause_q   <= mcause_d;
        mcycle_q   <= mcycle_d;
        minstret_q <= minstret_d;
    end

    assign mtvec_out = mtvec_q;
    assign mepc_out  = mepc_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_csr.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_regfile_csr
// Purpose  : Directed, table-driven self-checking bench for regfile_csr.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_csr;

    localparam logic [31:0] MTVEC_RST = 32'h0000_0100;

    logic        clk;
    logic        rstn;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        reg_w_enabled;
    logic [4:0]  reg_w_addr;
    logic [31:0] reg_w_data;
    logic [11:0] csr_r_addr;
    logic [31:0] csr_r_data;
    logic        csr_r_illegal;
    logic        csr_w_enabled;
    logic [11:0] csr_w_addr;
    logic [31:0] csr_w_data;
    logic        retire;
    logic        trap_valid;
    logic [31:0] trap_cause, trap_pc;
    logic [31:0] mtvec_out, mepc_out;

    int checks   = 0;
    int failures = 0;

    regfile_csr #(
        .MTVEC_RESET (MTVEC_RST),
        .BYPASS      (1'b1)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .rs1_addr      (rs1_addr),
        .rs1_data      (rs1_data),
        .rs2_addr      (rs2_addr),
        .rs2_data      (rs2_data),
        .reg_w_enabled (reg_w_enabled),
        .reg_w_addr    (reg_w_addr),
        .reg_w_data    (reg_w_data),
        .csr_r_addr    (csr_r_addr),
        .csr_r_data    (csr_r_data),
        .csr_r_illegal (csr_r_illegal),
        .csr_w_enabled (csr_w_enabled),
        .csr_w_addr    (csr_w_addr),
        .csr_w_data    (csr_w_data),
        .retire        (retire),
        .trap_valid    (trap_valid),
        .trap_cause    (trap_cause),
        .trap_pc       (trap_pc),
        .mtvec_out     (mtvec_out),
        .mepc_out      (mepc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
    } reg_vec_t;

    typedef struct {
        logic        we;
        logic [11:0] wa;
        logic [31:0] wd;
        logic [11:0] ra;
        logic [31:0] ed;
        logic        eill;
    } csr_vec_t;

    reg_vec_t rv [8];
    csr_vec_t cv [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        reg_w_enabled = 1'b0;
        reg_w_addr    = 5'd0;
        reg_w_data    = 32'h0;
        csr_w_enabled = 1'b0;
        csr_w_addr    = 12'h0;
        csr_w_data    = 32'h0;
        retire        = 1'b0;
        trap_valid    = 1'b0;
        trap_cause    = 32'h0;
        trap_pc       = 32'h0;
        rs1_addr      = 5'd0;
        rs2_addr      = 5'd0;
        csr_r_addr    = 12'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        csr_w_enabled = 1'b1;
        csr_w_addr    = a;
        csr_w_data    = d;
    endtask

    task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr_r_addr = a;
        #2;
        chk(name, csr_r_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rv[0] = '{1'b1, 5'd0,  32'h0000_DEAD, 5'd0,  5'd0,  32'h0,         32'h0};
        rv[1] = '{1'b1, 5'd5,  32'h0000_1234, 5'd0,  5'd5,  32'h0,         32'h0000_1234};
        rv[2] = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd5,  32'h0000_1234, 32'h0000_1234};
        rv[3] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31, 5'd5,  32'hFFFF_FFFF, 32'h0000_1234};
        rv[4] = '{1'b1, 5'd5,  32'h0000_5555, 5'd5,  5'd31, 32'h0000_5555, 32'hFFFF_FFFF};
        rv[5] = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd5,  32'h0,         32'h0000_5555};
        rv[6] = '{1'b1, 5'd1,  32'h0000_A5A5, 5'd2,  5'd1,  32'h0,         32'h0000_A5A5};
        rv[7] = '{1'b0, 5'd0,  32'h0,         5'd1,  5'd31, 32'h0000_A5A5, 32'hFFFF_FFFF};

        cv[0]  = '{1'b0, 12'h000, 32'h0,         12'h300, 32'h0,         1'b0};
        cv[1]  = '{1'b1, 12'h300, 32'hFFFF_FFFF, 12'h300, 32'h0000_0088, 1'b0};
        cv[2]  = '{1'b0, 12'h000, 32'h0,         12'h300, 32'h0000_0088, 1'b0};
        cv[3]  = '{1'b1, 12'h305, 32'h0000_1237, 12'h305, 32'h0000_1234, 1'b0};
        cv[4]  = '{1'b0, 12'h000, 32'h0,         12'h305, 32'h0000_1234, 1'b0};
        cv[5]  = '{1'b1, 12'h341, 32'hFFFF_FFFF, 12'h341, 32'hFFFF_FFFC, 1'b0};
        cv[6]  = '{1'b1, 12'h340, 32'hCAFE_BABE, 12'h341, 32'hFFFF_FFFC, 1'b0};
        cv[7]  = '{1'b0, 12'h000, 32'h0,         12'h340, 32'hCAFE_BABE, 1'b0};
        cv[8]  = '{1'b1, 12'h304, 32'h0000_0888, 12'h304, 32'h0000_0888, 1'b0};
        cv[9]  = '{1'b1, 12'h342, 32'h8000_000B, 12'h342, 32'h8000_000B, 1'b0};
        cv[10] = '{1'b0, 12'h000, 32'h0,         12'h7C0, 32'h0,         1'b1};
        cv[11] = '{1'b1, 12'h7C0, 32'h0000_0001, 12'h7C0, 32'h0,         1'b1};
        cv[12] = '{1'b0, 12'h000, 32'h0,         12'hC82, 32'h0,         1'b0};
        cv[13] = '{1'b1, 12'hC02, 32'h0000_0005, 12'hC02, 32'h0,         1'b0};
        cv[14] = '{1'b0, 12'h000, 32'h0,         12'hC02, 32'h0,         1'b0};

        // Reset for two edges, then release
        idle();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        #2;
        chk("reset_mtvec_out", mtvec_out, MTVEC_RST);
        chk("reset_mepc_out", mepc_out, 32'h0);
        rd("reset_mcycle0", 12'hB00, 32'h0);
        step();
        rd("reset_mcycle1", 12'hB00, 32'h1);
        rd("reset_mcycleh", 12'hB80, 32'h0);
        for (int i = 0; i < 16; i++) begin
            step();
            rs1_addr = 5'(i);
            rs2_addr = 5'(i + 16);
            #2;
            chk($sformatf("reset_rs1_x%0d", i), rs1_data, 32'h0);
            chk($sformatf("reset_rs2_x%0d", i + 16), rs2_data, 32'h0);
        end

        // Integer register file vectors
        for (int i = 0; i < 8; i++) begin
            step();
            reg_w_enabled = rv[i].we;
            reg_w_addr    = rv[i].wa;
            reg_w_data    = rv[i].wd;
            rs1_addr      = rv[i].a1;
            rs2_addr      = rv[i].a2;
            #2;
            chk($sformatf("reg_vec%0d_rs1", i), rs1_data, rv[i].e1);
            chk($sformatf("reg_vec%0d_rs2", i), rs2_data, rv[i].e2);
        end

        // CSR vectors (non-counter registers, illegal and read-only)
        for (int i = 0; i < 15; i++) begin
            step();
            csr_w_enabled = cv[i].we;
            csr_w_addr    = cv[i].wa;
            csr_w_data    = cv[i].wd;
            csr_r_addr    = cv[i].ra;
            #2;
            chk($sformatf("csr_vec%0d_data", i), csr_r_data, cv[i].ed);
            chk($sformatf("csr_vec%0d_illegal", i), {31'd0, csr_r_illegal}, {31'd0, cv[i].eill});
        end
        step();
        #2;
        chk("mtvec_out_written", mtvec_out, 32'h0000_1234);
        chk("mepc_out_written", mepc_out, 32'hFFFF_FFFC);

        // Ten retire pulses separated by idle cycles
        for (int k = 0; k < 10; k++) begin
            step();
            retire = 1'b1;
            step();
        end
        step();
        rd("instret_10", 12'hC02, 32'd10);
        rd("instreth_0", 12'hC82, 32'd0);

        // Trap beats same-cycle mepc write; retire still counts
        step();
        csr_wr(12'h300, 32'h0000_0008);
        step();
        trap_valid = 1'b1;
        trap_pc    = 32'h0000_1003;
        trap_cause = 32'd2;
        retire     = 1'b1;
        csr_wr(12'h341, 32'h0000_0055);
        step();
        rd("trap_mepc", 12'h341, 32'h0000_1000);
        chk("trap_mepc_out", mepc_out, 32'h0000_1000);
        rd("trap_mcause", 12'h342, 32'd2);
        step();
        rd("trap_mstatus", 12'h300, 32'h0000_0080);
        rd("trap_instret", 12'hC02, 32'd11);

        // Trap with a same-cycle write to an unrelated CSR
        step();
        trap_valid = 1'b1;
        trap_pc    = 32'h0000_2000;
        trap_cause = 32'h8000_0007;
        csr_wr(12'h340, 32'h0000_0ABC);
        step();
        rd("trap2_mscratch", 12'h340, 32'h0000_0ABC);
        rd("trap2_mstatus", 12'h300, 32'h0);
        step();
        rd("trap2_mcause", 12'h342, 32'h8000_0007);

        // minstret low-half wrap carries into minstreth
        step();
        csr_wr(12'hB02, 32'hFFFF_FFFF);
        step();
        retire = 1'b1;
        rd("minstret_allones", 12'hB02, 32'hFFFF_FFFF);
        step();
        rd("minstret_wrap_lo", 12'hB02, 32'h0);
        rd("minstret_wrap_hi", 12'hB82, 32'h1);

        // Write to mcycle wins over the increment
        step();
        csr_wr(12'hB00, 32'h0000_0100);
        rd("mcycle_bypass", 12'hB00, 32'h0000_0100);
        step();
        rd("mcycle_written", 12'hB00, 32'h0000_0100);
        step();
        rd("mcycle_inc", 12'hB00, 32'h0000_0101);

        // Low-half carry into mcycleh, then full 64-bit wrap
        step();
        csr_wr(12'hB00, 32'hFFFF_FFFF);
        step();
        rd("mcycleh_before_carry", 12'hB80, 32'h0);
        step();
        rd("mcycleh_after_carry", 12'hB80, 32'h1);
        rd("mcycle_after_carry", 12'hB00, 32'h0);
        step();
        csr_wr(12'hB80, 32'hFFFF_FFFF);
        rd("mcycle_before_hwrite", 12'hB00, 32'h1);
        step();
        csr_wr(12'hB00, 32'hFFFF_FFFF);
        rd("mcycleh_written", 12'hB80, 32'hFFFF_FFFF);
        rd("cycle_lo_held", 12'hC00, 32'h1);
        step();
        rd("mcycle_allones", 12'hB00, 32'hFFFF_FFFF);
        step();
        rd("mcycle_wrap_lo", 12'hB00, 32'h0);
        rd("mcycle_wrap_hi", 12'hB80, 32'h0);

        // Write to read-only cycle alias is ignored
        step();
        csr_wr(12'hB00, 32'h0000_0200);
        step();
        csr_wr(12'hC00, 32'h0000_0005);
        rd("cycle_ro_write", 12'hC00, 32'h0000_0200);
        chk("cycle_ro_illegal", {31'd0, csr_r_illegal}, 32'h0);
        step();
        rd("cycle_ro_inc", 12'hC00, 32'h0000_0201);

        // Reset overrides write, retire and trap in the same cycle
        step();
        rstn          = 1'b0;
        reg_w_enabled = 1'b1;
        reg_w_addr    = 5'd5;
        reg_w_data    = 32'h0000_0077;
        csr_wr(12'h305, 32'h0000_4000);
        trap_valid    = 1'b1;
        trap_pc       = 32'h0000_3000;
        trap_cause    = 32'd5;
        retire        = 1'b1;
        step();
        rstn     = 1'b1;
        rs1_addr = 5'd5;
        rs2_addr = 5'd31;
        #2;
        chk("midreset_x5", rs1_data, 32'h0);
        chk("midreset_x31", rs2_data, 32'h0);
        chk("midreset_mtvec_out", mtvec_out, MTVEC_RST);
        chk("midreset_mepc_out", mepc_out, 32'h0);
        rd("midreset_minstret", 12'hB02, 32'h0);
        rd("midreset_mcycle", 12'hB00, 32'h0);
        step();
        rd("midreset_mcause", 12'h342, 32'h0);
        rd("midreset_mstatus", 12'h300, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
